// File: rtl/spike_injector.sv
// Spike injector: buffers routed spike packets written by the host in a
// first-word-fall-through FIFO and releases them downstream as one burst
// per start pulse. The burst FSM (IDLE/SEND/DONE) gates the downstream
// port, and its state is visible on state_o.
//
// Handshakes:
//   Upstream:   a packet transfers on a rising edge where wr_en=1 and
//               wr_ready=1. wr_en while wr_ready=0 is dropped and sets the
//               sticky overflow_error flag.
//   Downstream: empty_out=0 means "valid" and dout holds the head packet.
//               ren_in is the consumer's read strobe. A packet transfers on
//               a rising edge where empty_out=0 and ren_in=1. ren_in while
//               empty_out=1 has no effect.
module spike_injector #(
  parameter int PACKET_WIDTH = 30,
  parameter int DEPTH        = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    start,
  input  logic                    ren_in,
  output logic                    empty_out,
  output logic [PACKET_WIDTH-1:0] dout,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  sent_count,
  output logic                    overflow_error,
  output logic [1:0]              state_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          count_q, count_d;
  logic [COUNT_WIDTH-1:0]  sent_q, sent_d;
  logic                    ovf_q, ovf_d;
  logic [PACKET_WIDTH-1:0] mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic empty_c;

  // DEPTH is a power of two, so the occupancy MSB is set only at DEPTH.
  assign full = count_q[PTR_W];
  assign push = wr_en & ~full;
  assign pop  = ren_in & ~empty_c;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a burst ends on the first edge that sees the FIFO empty,
  // so packets written during SEND join the current burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SEND;
      ST_SEND: if (count_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the downstream port is only opened while sending.
  always_comb begin
    busy    = (state_q == ST_SEND);
    done    = (state_q == ST_DONE);
    empty_c = !((state_q == ST_SEND) && (count_q != '0));
  end

  // FIFO pointer, occupancy and status next-state logic.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sent_d   = sent_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      sent_d   = sent_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_en && full) ovf_d = 1'b1;
  end

  // FIFO pointer, occupancy and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      ovf_q    <= ovf_d;
    end
  end

  // Packet storage; contents are meaningless while the FIFO is empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign dout           = mem_q[rd_ptr_q];
  assign empty_out      = empty_c;
  assign wr_ready       = ~full;
  assign sent_count     = sent_q;
  assign overflow_error = ovf_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_spike_injector.sv
// Bench for spike_injector: a queue-based reference model is compared with
// the DUT on every falling edge, and directed scenarios pin key values.
module tb_spike_injector;

  localparam int PW    = 30;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  localparam int M_IDLE = 0;
  localparam int M_SEND = 1;
  localparam int M_DONE = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          wr_ready;
  logic          start;
  logic          ren_in;
  logic          empty_out;
  logic [PW-1:0] dout;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;
  logic          overflow_error;
  logic [1:0]    state_o;

  spike_injector #(
    .PACKET_WIDTH (PW),
    .DEPTH        (DEPTH),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .start          (start),
    .ren_in         (ren_in),
    .empty_out      (empty_out),
    .dout           (dout),
    .busy           (busy),
    .done           (done),
    .sent_count     (sent_count),
    .overflow_error (overflow_error),
    .state_o        (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [PW-1:0] exp_q[$];
  int            m_mode;
  logic [CW-1:0] m_sent;
  logic          m_ovf;
  int            m_occ;
  bit            m_offered;
  bit            m_full;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode = M_IDLE;
      m_sent = '0;
      m_ovf  = 1'b0;
    end else begin
      m_occ     = exp_q.size();
      m_offered = (m_mode == M_SEND) && (m_occ > 0);
      m_full    = (m_occ == DEPTH);
      if (wr_en && m_full) m_ovf = 1'b1;
      case (m_mode)
        M_IDLE:  if (start) m_mode = M_SEND;
        M_SEND:  if (m_occ == 0) m_mode = M_DONE;
        default: m_mode = M_IDLE;
      endcase
      if (ren_in && m_offered) begin
        void'(exp_q.pop_front());
        m_sent = m_sent + 1'b1;
      end
      if (wr_en && !m_full) exp_q.push_back(wr_data);
    end
  end

  // ---------------- scoreboard state ----------------
  int          n_vec;
  int          n_err;
  bit          chk_en;
  bit          exp_empty;
  int          pop_cnt;
  int          done_cnt;
  int          nonempty_cnt;
  logic [7:0]  pop_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [7:0] axon);
    logic [31:0] r;
    r = $urandom;
    return {r[8:0], r[17:9], axon, r[21:18]};
  endfunction

  task automatic push_pkt(input logic [PW-1:0] pkt);
    wr_en   = 1'b1;
    wr_data = pkt;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    start  = 1'b0;
    ren_in = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
  endtask

  task automatic clr_mon();
    pop_cnt      = 0;
    done_cnt     = 0;
    nonempty_cnt = 0;
    pop_log.delete();
  endtask

  // ---------------- main ----------------
  initial begin : main
    logic [31:0] r;
    n_vec   = 0;
    n_err   = 0;
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    start   = 1'b0;
    ren_in  = 1'b0;
    clr_mon();

    // Per-cycle compare against the model, plus a pop/done monitor.
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          exp_empty = !((m_mode == M_SEND) && (exp_q.size() > 0));
          check("empty_out", empty_out, exp_empty);
          if (!exp_empty) check("dout", dout, exp_q[0]);
          check("wr_ready", wr_ready, exp_q.size() != DEPTH);
          check("busy", busy, m_mode == M_SEND);
          check("done", done, m_mode == M_DONE);
          check("sent_count", sent_count, m_sent);
          check("overflow_error", overflow_error, m_ovf);
          if (ren_in && !empty_out) begin
            pop_cnt++;
            pop_log.push_back(dout[11:4]);
          end
          if (done) done_cnt++;
          if (!empty_out) nonempty_cnt++;
        end
      end
    join_none

    // Reset state.
    reset_dut();
    chk_en = 1'b1;
    check("rst_empty_out", empty_out, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_count, 0);
    check("rst_ovf", overflow_error, 0);

    // Basic burst of axons 5, 6, 7.
    clr_mon();
    push_pkt(mk_pkt(8'd5));
    push_pkt(mk_pkt(8'd6));
    push_pkt(mk_pkt(8'd7));
    pulse_start();
    ren_in = 1'b1;
    repeat (8) tick();
    ren_in = 1'b0;
    check("burst_pops", pop_cnt, 3);
    for (int i = 0; i < 3; i++) check("burst_axon", pop_log[i], 5 + i);
    check("burst_done_cnt", done_cnt, 1);
    check("burst_sent", sent_count, 3);
    check("burst_empty", empty_out, 1);
    check("model_sent", m_sent, 3);

    // Gating: loaded but not started.
    reset_dut();
    clr_mon();
    push_pkt(mk_pkt(8'd1));
    push_pkt(mk_pkt(8'd2));
    ren_in = 1'b1;
    repeat (10) tick();
    check("gate_pops", pop_cnt, 0);
    check("gate_nonempty", nonempty_cnt, 0);
    check("gate_sent", sent_count, 0);
    pulse_start();
    repeat (6) tick();
    ren_in = 1'b0;
    check("gate_drain_pops", pop_cnt, 2);
    check("gate_drain_done", done_cnt, 1);
    check("gate_drain_sent", sent_count, 2);

    // Full and overflow.
    reset_dut();
    clr_mon();
    for (int i = 0; i < DEPTH; i++) push_pkt(mk_pkt(8'(i)));
    check("full_wr_ready", wr_ready, 0);
    check("full_ovf_before", overflow_error, 0);
    push_pkt(mk_pkt(8'd99));
    check("ovf_set", overflow_error, 1);
    check("ovf_wr_ready", wr_ready, 0);
    check("model_ovf", m_ovf, 1);
    pulse_start();
    ren_in = 1'b1;
    repeat (22) tick();
    ren_in = 1'b0;
    check("full_pops", pop_cnt, 16);
    for (int i = 0; i < DEPTH; i++) check("full_order", pop_log[i], i);
    check("full_done_cnt", done_cnt, 1);
    check("full_sent", sent_count, 16);
    check("ovf_sticky", overflow_error, 1);

    // Reset in the middle of a burst.
    clr_mon();
    for (int i = 0; i < 5; i++) push_pkt(mk_pkt(8'(20 + i)));
    pulse_start();
    ren_in = 1'b1;
    repeat (2) tick();
    ren_in = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n  = 1'b1;
    check("mid_pops", pop_cnt, 2);
    check("mid_state", state_o, 0);
    check("mid_empty", empty_out, 1);
    check("mid_sent", sent_count, 0);
    check("mid_ovf", overflow_error, 0);
    check("mid_busy", busy, 0);
    clr_mon();
    ren_in = 1'b1;
    repeat (5) tick();
    ren_in = 1'b0;
    check("mid_no_done", done_cnt, 0);
    check("mid_no_pops", pop_cnt, 0);
    push_pkt(mk_pkt(8'hAB));
    pulse_start();
    ren_in = 1'b1;
    repeat (5) tick();
    ren_in = 1'b0;
    check("mid_new_pops", pop_cnt, 1);
    check("mid_new_axon", pop_log[0], 8'hAB);
    check("mid_new_done", done_cnt, 1);
    check("mid_new_sent", sent_count, 1);

    // Simultaneous write and pop at occupancy 1, wrapping the pointers.
    reset_dut();
    clr_mon();
    push_pkt(mk_pkt(8'd1));
    pulse_start();
    tick();
    check("sim_busy", busy, 1);
    check("sim_empty", empty_out, 0);
    wr_en  = 1'b1;
    ren_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = mk_pkt(8'(100 + i));
      tick();
    end
    wr_en = 1'b0;
    check("sim_no_done", done_cnt, 0);
    check("sim_busy_after", busy, 1);
    check("sim_sent_40", sent_count, 40);
    check("model_occ_1", exp_q.size(), 1);
    repeat (4) tick();
    ren_in = 1'b0;
    check("sim_sent_41", sent_count, 41);
    check("sim_done_cnt", done_cnt, 1);
    check("sim_first", pop_log[0], 1);
    check("sim_last", pop_log[40], 139);

    // Start with an empty FIFO: done two cycles after start.
    reset_dut();
    clr_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("es_c1_done", done, 0);
    check("es_c1_busy", busy, 1);
    check("es_c1_empty", empty_out, 1);
    tick();
    check("es_c2_done", done, 1);
    check("es_c2_busy", busy, 0);
    tick();
    check("es_c3_done", done, 0);
    check("es_c3_state", state_o, 0);

    // Backpressure: ren_in toggling 1,0,1,0.
    for (int i = 0; i < 4; i++) push_pkt(mk_pkt(8'(40 + i)));
    pulse_start();
    clr_mon();
    for (int i = 0; i < 8; i++) begin
      ren_in = (i % 2 == 0);
      tick();
      if (i == 1) check("bp_pops_2cyc", pop_cnt, 1);
    end
    ren_in = 1'b0;
    repeat (3) tick();
    check("bp_pops", pop_cnt, 4);
    for (int i = 0; i < 4; i++) check("bp_order", pop_log[i], 40 + i);
    check("bp_done_cnt", done_cnt, 1);

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      r       = $urandom;
      wr_data = r[PW-1:0];
      wr_en   = ($urandom_range(0, 99) < 45);
      start   = ($urandom_range(0, 99) < 8);
      ren_in  = ($urandom_range(0, 99) < 60);
      rst_n   = ($urandom_range(0, 499) != 0);
      tick();
    end
    wr_en  = 1'b0;
    rst_n  = 1'b1;
    start  = 1'b0;
    ren_in = 1'b1;
    repeat (3) tick();
    pulse_start();
    repeat (24) tick();
    ren_in = 1'b0;
    check("rand_drained", empty_out, 1);
    check("rand_model_empty", exp_q.size(), 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_injector.md
SPIKE_INJECTOR -- requirements
Module: spike_injector

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 30: width of a full routed spike packet.
REQ-002 SHALL have parameter DEPTH, default 16: packet FIFO entries; must be a power of two, at least 2.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16: width of the sent-packet counter.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1: host pushes wr_data this cycle.
REQ-007 SHALL have port wr_data, input, PACKET_WIDTH: packet with dx[29:21], dy[20:12], axon[11:4], tick[3:0], passed through unmodified.
REQ-008 SHALL have port wr_ready, input-side status output, 1: equals not full.
REQ-009 SHALL have port start, input, 1: one-cycle pulse that releases the loaded burst.
REQ-010 SHALL have port ren_in, input, 1: read enable from the downstream core's router input port.
REQ-011 SHALL have port empty_out, output, 1: no packet offered downstream.
REQ-012 SHALL have port dout, output, PACKET_WIDTH: head packet, valid whenever empty_out is 0.
REQ-013 SHALL have port busy, output, 1: high in SEND.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a burst has fully drained.
REQ-015 SHALL have port sent_count, output, COUNT_WIDTH: packets consumed since reset.
REQ-016 SHALL have port overflow_error, output, 1: sticky; set when wr_en arrives while full.

Function
REQ-017 SHALL hold packets in a DEPTH-entry first-word-fall-through FIFO, with read/write pointers of log2(DEPTH) bits and an occupancy counter of log2(DEPTH)+1 bits.
REQ-018 SHALL accept a write only when wr_en=1 and full=0; the packet is visible at the head one cycle later.
REQ-019 SHALL ignore wr_en while full (FIFO contents unchanged) and set overflow_error, which stays set until reset.
REQ-020 SHALL accept writes in every state.
REQ-021 SHALL drive empty_out = 1 unless state is SEND and the FIFO is non-empty.
REQ-022 SHALL drive dout from the head entry combinationally.
REQ-023 SHALL pop on a rising edge where ren_in=1 and empty_out=0.
  - ren_in while empty_out=1 is ignored.
  - Each pop increments sent_count modulo 2^COUNT_WIDTH.
REQ-024 SHALL, on a simultaneous accepted write and pop, leave occupancy unchanged and advance both pointers.
REQ-025 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-026 SHALL implement the FSM IDLE, SEND, DONE with these transitions:
  - IDLE -> SEND on start=1.
  - SEND -> DONE in the cycle after occupancy reaches 0.
  - DONE -> IDLE unconditionally after one cycle.
REQ-027 SHALL ignore start in SEND and DONE.
REQ-028 SHALL, on start with an empty FIFO, enter SEND, then DONE on the next cycle, then IDLE.
REQ-029 SHALL assert done only in DONE, for exactly one cycle per burst.
REQ-030 SHALL, when writes arrive during SEND, send them in the same burst; DONE is entered only when occupancy is 0 at a clock edge.
REQ-031 SHALL drive busy = (state == SEND).

Reset
REQ-032 SHALL, on rst_n=0 at a rising edge, apply the following, regardless of state or in-flight handshakes:
  - state = IDLE; pointers and occupancy = 0 (FIFO data discarded).
  - sent_count = 0, overflow_error = 0.
  - empty_out = 1, busy = 0, done = 0, wr_ready = 1.
REQ-033 SHALL not require the FIFO storage array itself to be reset; dout is don't-care while empty_out=1.

Verification
REQ-034 Basic burst:
  - Stimulus: write 3 packets (axon 5, 6, 7); pulse start; hold ren_in=1.
  - Response: dout shows axon 5, 6, 7 on consecutive cycles; empty_out=1 after the third pop; done pulses once; sent_count=3.
REQ-035 Gating:
  - Stimulus: load 2 packets; do not pulse start; ren_in=1 for 10 cycles.
  - Response: empty_out=1 throughout; no pops; sent_count=0.
REQ-036 Full/overflow:
  - Stimulus: write 17 packets with DEPTH=16.
  - Response: wr_ready=0 after the 16th write; the 17th is dropped and overflow_error=1.
  - Then start and drain: exactly 16 packets emerge in order, followed by done.
REQ-037 Simultaneous and wrap:
  - Stimulus: in SEND with occupancy 1, write and pop in the same cycle, repeated 40 times.
  - Response: occupancy stays 1; pointers wrap; no done until writes stop; sent_count=41 after final drain.
REQ-038 Empty start and backpressure:
  - Stimulus: start with an empty FIFO.
  - Response: done exactly 2 cycles after start.
  - Stimulus: a burst of 4 with ren_in toggling 1,0,1,0.
  - Response: one pop per ren_in=1 cycle.
REQ-039 Reset mid-burst:
  - Stimulus: drive rst_n=0 for one cycle after 2 of 5 packets have been popped.
  - Response: state IDLE; empty_out=1; sent_count=0; overflow_error=0; done never pulses; a subsequent write and start sends only the new packet.
